// File: rtl/sata_tx_align_sched.sv
// sata_tx_align_sched: schedules link dwords, ALIGNP bursts and SYNCP fill onto a 16-bit GTX TX datapath.
// Every decision is taken on the first word of a dword, so a dword is never split.
module sata_tx_align_sched #(
    parameter int ALIGN_PERIOD = 256,
    parameter int ALIGN_COUNT  = 2,
    parameter int CNT_W        = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_align,
    input  logic [15:0] link_data,
    input  logic [1:0]  link_charisk,
    input  logic        link_valid,
    output logic        link_ready,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_charisk,
    output logic        tx_lword,
    output logic        align_active,
    output logic        underrun_err
);
    localparam int KW = $clog2(ALIGN_COUNT + 1);

    typedef enum logic [1:0] {DIS, ALN, DAT, SYN} state_t;

    state_t            state, cur;
    logic              phase, pending, due, kdone, pass0, is_align;
    logic [CNT_W-1:0]  cnt;
    logic [KW-1:0]     k;
    logic [15:0]       data_n;
    logic [1:0]        charisk_n;

    assign due      = pending | (cnt == CNT_W'(ALIGN_PERIOD));
    assign kdone    = k == KW'(ALIGN_COUNT);
    assign is_align = (cur == ALN) | (cur == DIS);

    // cur is the kind of the dword being emitted this cycle; it only changes on the first word
    always_comb begin
        cur   = state;
        pass0 = 1'b0;
        if (!phase) begin
            if (state == ALN && !kdone)
                cur = ALN;
            else if (!enable)
                cur = DIS;
            else if (state == DIS || due)
                cur = ALN;
            else begin
                pass0 = 1'b1;
                cur   = link_valid ? DAT : SYN;
            end
        end
        link_ready = phase ? (state == DAT) : pass0;
        data_n     = phase ? 16'h7B4A : 16'h4ABC;
        charisk_n  = phase ? 2'b00 : 2'b01;
        if (cur == SYN) begin
            data_n    = phase ? 16'hB5B5 : 16'h957C;
            charisk_n = phase ? 2'b00 : 2'b01;
        end else if (cur == DAT) begin
            data_n    = link_valid ? link_data : 16'h0000;
            charisk_n = link_valid ? link_charisk : 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase        <= 1'b0;
            state        <= DIS;
            cnt          <= '0;
            pending      <= 1'b0;
            k            <= '0;
            tx_data      <= 16'h4ABC;
            tx_charisk   <= 2'b01;
            tx_lword     <= 1'b0;
            align_active <= 1'b1;
            underrun_err <= 1'b0;
        end else begin
            phase        <= ~phase;
            state        <= cur;
            pending      <= is_align ? 1'b0 : (pending | force_align);
            cnt          <= is_align ? '0 : (!phase && cnt != CNT_W'(ALIGN_PERIOD)) ? cnt + 1'b1 : cnt;
            k            <= (!phase && cur == ALN) ? ((state == ALN && !kdone) ? k + 1'b1 : KW'(1)) : k;
            tx_data      <= data_n;
            tx_charisk   <= charisk_n;
            tx_lword     <= phase;
            align_active <= is_align;
            underrun_err <= phase && cur == DAT && !link_valid;
        end
    end
endmodule
